// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time and sends it as an 8N1-style UART frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_r_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
`ifdef FIFO_UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              pop;
    logic              done;
    logic              bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state, pop request and frame-done decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        done    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // reset gates the pop so nothing is requested while held in reset
                if (!fifo_empty && reset) begin
                    pop     = 1'b1;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = fifo_dout;
                idx_d   = '0;
                cnt_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d   = ^fifo_dout;
`endif
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, so the registered tx only moves at bit edges.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters, shift register and registered line output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign fifo_r_en  = pop;
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small queue-backed FIFO model.
// Runs with CLKS_PER_BIT=4; parity test is built only with FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FC = NB * CPB;

    logic       clk;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_r_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem [0:63];
    int         wr_ptr;
    int         rd_ptr;
    int         pop_cnt;
    int         done_cnt;
    int         bad_pop;
    int         checks;
    int         failures;

    fifo_uart_tx #(
        .WIDTH(8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_r_en(fifo_r_en),
        .tx(tx),
        .busy(busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO read side plus pop/frame-done bookkeeping.
    always @(posedge clk) begin
        if (reset && fifo_r_en) begin
            if (fifo_empty || busy) bad_pop <= bad_pop + 1;
            fifo_dout <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
            pop_cnt   <= pop_cnt + 1;
        end
        if (reset && frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [63:0] exp_frame(input logic [7:0] d);
        logic [10:0] bits;
        logic [63:0] s;
`ifdef FIFO_UART_TX_PARITY_EN
        bits = {1'b1, ^d, d, 1'b0};
`else
        bits = {1'b1, 1'b1, d, 1'b0};
`endif
        s = '0;
        for (int i = 0; i < FC; i++) s[i] = bits[i / CPB];
        return s;
    endfunction

    // Waits for the start edge, then records tx for one frame.
    task automatic capture(output logic [63:0] s, output int done_at,
                           output int wait_n);
        s       = '0;
        done_at = -1;
        wait_n  = 0;
        while (tx !== 1'b0 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        if (tx !== 1'b0) begin
            wait_n = -1;
            return;
        end
        for (int i = 0; i < FC; i++) begin
            s[i] = tx;
            if (frame_done === 1'b1 && done_at < 0) done_at = i;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int n;
        push(8'h55);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || fifo_r_en !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d tx=%b r_en=%b busy=%b want 1/0/0",
                         i, tx, fifo_r_en, busy);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (fifo_r_en !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_pop r_en=%b want 1", fifo_r_en);
        end
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_drain busy=%b want 0 (timeout)", busy);
        end
    endtask

    task automatic test_single_byte;
        logic [63:0] s;
        int          d_at;
        int          w;
        int          p0;
        int          f0;
        p0 = pop_cnt;
        f0 = done_cnt;
        push(8'hA5);
        capture(s, d_at, w);
        checks++;
        if (w !== 3) begin
            failures++;
            $display("FAIL single_latency got=%0d want 3", w);
        end
        checks++;
        if (s !== exp_frame(8'hA5)) begin
            failures++;
            $display("FAIL single_frame got=%h want %h", s, exp_frame(8'hA5));
        end
        checks++;
        if (d_at !== FC - 1) begin
            failures++;
            $display("FAIL single_done_pos got=%0d want %0d", d_at, FC - 1);
        end
        checks++;
        if (pop_cnt - p0 !== 1) begin
            failures++;
            $display("FAIL single_pops got=%0d want 1", pop_cnt - p0);
        end
        checks++;
        if (done_cnt - f0 !== 1) begin
            failures++;
            $display("FAIL single_dones got=%0d want 1", done_cnt - f0);
        end
    endtask

    task automatic test_empty;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_r_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL empty_idle cyc=%0d r_en=%b tx=%b busy=%b want 0/1/0",
                         i, fifo_r_en, tx, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  data [3];
        logic [63:0] s;
        int          d_at;
        int          w;
        int          p0;
        data[0] = 8'h00;
        data[1] = 8'hFF;
        data[2] = 8'h3C;
        p0 = pop_cnt;
        push(data[0]);
        repeat (2) @(negedge clk);
        push(data[1]);
        push(data[2]);
        for (int f = 0; f < 3; f++) begin
            capture(s, d_at, w);
            checks++;
            if (w !== ((f == 0) ? 1 : 3)) begin
                failures++;
                $display("FAIL burst_gap frame=%0d got=%0d want %0d",
                         f, w, (f == 0) ? 1 : 3);
            end
            checks++;
            if (s !== exp_frame(data[f])) begin
                failures++;
                $display("FAIL burst_frame frame=%0d got=%h want %h",
                         f, s, exp_frame(data[f]));
            end
            checks++;
            if (d_at !== FC - 1) begin
                failures++;
                $display("FAIL burst_done_pos frame=%0d got=%0d want %0d",
                         f, d_at, FC - 1);
            end
        end
        checks++;
        if (pop_cnt - p0 !== 3) begin
            failures++;
            $display("FAIL burst_pops got=%0d want 3", pop_cnt - p0);
        end
        checks++;
        if (fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL burst_empty got=%b want 1", fifo_empty);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [63:0] s;
        int          d_at;
        int          w;
        int          n;
        push(8'h37);
        push(8'hC3);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (17) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL mid_data_bit3 tx=%b want 0", tx);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_r_en !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset tx=%b busy=%b r_en=%b want 1/0/0",
                     tx, busy, fifo_r_en);
        end
        @(negedge clk);
        reset = 1'b1;
        capture(s, d_at, w);
        checks++;
        if (w !== 3) begin
            failures++;
            $display("FAIL mid_restart_latency got=%0d want 3", w);
        end
        checks++;
        if (s !== exp_frame(8'hC3)) begin
            failures++;
            $display("FAIL mid_restart_frame got=%h want %h", s, exp_frame(8'hC3));
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity;
        logic [63:0] s;
        int          d_at;
        int          w;
        push(8'h07);
        capture(s, d_at, w);
        checks++;
        if (s[36] !== 1'b1 || s !== exp_frame(8'h07)) begin
            failures++;
            $display("FAIL parity_07 got=%h want %h", s, exp_frame(8'h07));
        end
        checks++;
        if (d_at !== 43) begin
            failures++;
            $display("FAIL parity_len got=%0d want 43", d_at);
        end
        push(8'h03);
        capture(s, d_at, w);
        checks++;
        if (s[36] !== 1'b0 || s !== exp_frame(8'h03)) begin
            failures++;
            $display("FAIL parity_03 got=%h want %h", s, exp_frame(8'h03));
        end
    endtask
`endif

    initial begin
        reset    = 1'b0;
        wr_ptr   = 0;
        rd_ptr   = 0;
        pop_cnt  = 0;
        done_cnt = 0;
        bad_pop  = 0;
        checks   = 0;
        failures = 0;
        fifo_dout = '0;
        test_reset();
        test_single_byte();
        test_empty();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (bad_pop !== 0) begin
            failures++;
            $display("FAIL illegal_pops got=%0d want 0", bad_pop);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
